// File: rtl/nn_pkg.sv
// Shared definitions for the weight loader: loader states, stream byte width
// and a small helper for counter sizing.
package nn_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ASSEMBLE = 2'd1,
        WRITE    = 2'd2,
        DONE     = 2'd3
    } state_t;

    // Width of a counter that must hold values 0..n-1; never narrower than 1 bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/weight_ram_loader_if.sv
// Byte stream handshake feeding the weight loader (valid/ready, 8-bit data).
interface weight_ram_loader_if;

    logic                     in_valid;
    logic [nn_pkg::BYTE_W-1:0] in_data;
    logic                     in_ready;

    // Producer side: drives bytes, observes ready.
    modport master (output in_valid, output in_data, input in_ready);
    // Loader side: consumes bytes, drives ready.
    modport slave  (input in_valid, input in_data, output in_ready);

endinterface

// File: rtl/weight_ram_loader_packer.sv
// Packs accepted stream bytes MSB-first into a WIDTH-bit word and flags the
// byte that completes the word.
module weight_byte_packer
    import nn_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              accept,
    input  logic [BYTE_W-1:0] in_data,
    output logic [WIDTH-1:0]  word,
    output logic              word_valid
);

    localparam int BYTES = WIDTH / BYTE_W;
    localparam int CNT_W = cnt_width(BYTES);

    logic [CNT_W-1:0] byte_idx_reg, byte_idx_next;
    logic [WIDTH-1:0] word_reg, word_next;
    logic [WIDTH-1:0] shifted;
    logic             last_byte;

    assign last_byte  = (byte_idx_reg == CNT_W'(BYTES - 1));
    assign word_valid = accept && last_byte;
    assign word       = word_reg;

    // A single-byte word has nothing to shift; wider words shift left by a byte.
    generate
        if (BYTES == 1) begin : g_single
            assign shifted = in_data;
        end else begin : g_multi
            assign shifted = {word_reg[WIDTH-BYTE_W-1:0], in_data};
        end
    endgenerate

    // Next byte index and word: start restarts counting, accept shifts a byte in.
    always_comb begin
        byte_idx_next = byte_idx_reg;
        word_next     = word_reg;
        if (start) begin
            byte_idx_next = '0;
        end else if (accept) begin
            word_next     = shifted;
            byte_idx_next = last_byte ? '0 : byte_idx_reg + CNT_W'(1);
        end
    end

    // Packer state registers; reset discards any partial word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_idx_reg <= '0;
            word_reg     <= '0;
        end else begin
            byte_idx_reg <= byte_idx_next;
            word_reg     <= word_next;
        end
    end

endmodule

// File: rtl/weight_ram_loader.sv
// Run-time loadable weight RAM: byte stream in, sequential word writes from
// address 0, ROM-compatible registered read port (out-of-range reads give 0).
module weight_ram_loader
    import nn_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 16,
    parameter int DEPTH_LOG = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                wr_start,
    weight_ram_loader_if.slave  in_bus,
    output logic                load_busy,
    output logic                load_done,
    output logic [15:0]         wr_count,
    input  logic [15:0]         addr_rd,
    output logic [WIDTH-1:0]    data_out
);

    state_t                 state_reg, state_next;
    logic [DEPTH_LOG-1:0]   wr_addr_reg, wr_addr_next;
    logic [15:0]            wr_count_reg, wr_count_next;
    logic                   pack_start;
    logic                   mem_we;
    logic                   accept;
    logic                   word_valid;
    logic [WIDTH-1:0]       packed_word;

    logic [WIDTH-1:0]       mem [DEPTH];

    assign accept          = in_bus.in_valid && (state_reg == ASSEMBLE);
    assign in_bus.in_ready = (state_reg == ASSEMBLE);
    assign load_busy       = (state_reg == ASSEMBLE) || (state_reg == WRITE);
    assign load_done       = (state_reg == DONE);
    assign wr_count        = wr_count_reg;

    weight_byte_packer #(
        .WIDTH (WIDTH)
    ) u_packer (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (pack_start),
        .accept     (accept),
        .in_data    (in_bus.in_data),
        .word       (packed_word),
        .word_valid (word_valid)
    );

    // Load sequencing: wr_start only honoured when no load is running.
    always_comb begin
        state_next    = state_reg;
        wr_addr_next  = wr_addr_reg;
        wr_count_next = wr_count_reg;
        pack_start    = 1'b0;
        mem_we        = 1'b0;
        unique case (state_reg)
            IDLE, DONE: begin
                if (wr_start) begin
                    state_next    = ASSEMBLE;
                    wr_addr_next  = '0;
                    wr_count_next = '0;
                    pack_start    = 1'b1;
                end
            end
            ASSEMBLE: begin
                if (word_valid) begin
                    state_next = WRITE;
                end
            end
            WRITE: begin
                mem_we        = 1'b1;
                wr_count_next = wr_count_reg + 16'd1;
                if (wr_addr_reg == DEPTH_LOG'(DEPTH - 1)) begin
                    state_next = DONE;
                end else begin
                    wr_addr_next = wr_addr_reg + DEPTH_LOG'(1);
                    state_next   = ASSEMBLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Loader control registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            wr_addr_reg  <= '0;
            wr_count_reg <= '0;
        end else begin
            state_reg    <= state_next;
            wr_addr_reg  <= wr_addr_next;
            wr_count_reg <= wr_count_next;
        end
    end

    // RAM write port; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[wr_addr_reg] <= packed_word;
        end
    end

    // Registered read port, read-first against a same-cycle write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out <= '0;
        end else if (32'(addr_rd) < DEPTH) begin
            data_out <= mem[addr_rd[DEPTH_LOG-1:0]];
        end else begin
            data_out <= '0;
        end
    end

endmodule

// File: tb/tb_weight_ram_loader.sv
// Scoreboard bench for weight_ram_loader (WIDTH=16, DEPTH=4): reads push the
// expected word into a queue, a monitor pops and compares when data returns.
module tb_weight_ram_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wr_start = 1'b0;
    logic        load_busy;
    logic        load_done;
    logic [15:0] wr_count;
    logic [15:0] addr_rd = 16'd0;
    logic [15:0] data_out;

    weight_ram_loader_if bus ();

    weight_ram_loader #(
        .WIDTH (16),
        .DEPTH (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_start  (wr_start),
        .in_bus    (bus),
        .load_busy (load_busy),
        .load_done (load_done),
        .wr_count  (wr_count),
        .addr_rd   (addr_rd),
        .data_out  (data_out)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int start_cyc;
    int done_lat;

    logic        rd_en = 1'b0;
    logic        rd_pend;
    logic [15:0] exp_q  [$];
    logic [15:0] addr_q [$];

    logic [15:0] load_w [4];
    logic [15:0] model  [4];

    always @(posedge clk) cyc <= cyc + 1;

    // A read issued before an edge returns data after that edge.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) rd_pend <= 1'b0;
        else        rd_pend <= rd_en;
    end

    // Scoreboard monitor.
    always @(negedge clk) begin
        if (rd_pend) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL rd_underflow: got data %h, required a queued expectation", data_out);
            end else begin
                logic [15:0] e;
                logic [15:0] a;
                e = exp_q.pop_front();
                a = addr_q.pop_front();
                if (data_out !== e) begin
                    bad++;
                    $display("FAIL rd_data addr=%h: got %h required %h", a, data_out, e);
                end else begin
                    $display("read addr=%h data=%h", a, data_out);
                end
            end
        end
    end

    // in_ready must only ever be high while assembling a word.
    always @(negedge clk) begin
        total++;
        if (bus.in_ready && (load_done || !load_busy)) begin
            bad++;
            $display("FAIL ready_invariant: in_ready=%b busy=%b done=%b", bus.in_ready, load_busy, load_done);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    // Issue one read at edge+1; expected value goes to the scoreboard.
    task automatic rd(input logic [15:0] a, input logic [15:0] e);
        addr_rd = a;
        rd_en   = 1'b1;
        exp_q.push_back(e);
        addr_q.push_back(a);
        @(posedge clk); #1;
        rd_en = 1'b0;
    endtask

    task automatic read_all();
        for (int i = 0; i < 4; i++) rd(16'(i), model[i]);
    endtask

    // Offer one byte until accepted; returns at edge+1 after acceptance.
    task automatic send_byte(input logic [7:0] b, input bit gaps);
        int guard;
        bit acc;
        guard = 0;
        bus.in_data = b;
        forever begin
            bus.in_valid = gaps ? ($urandom_range(0, 99) >= 35) : 1'b1;
            acc = bus.in_valid && bus.in_ready;
            @(posedge clk); #1;
            if (acc) break;
            guard++;
            if (guard > 500) begin
                bad++;
                total++;
                $display("FAIL send_timeout: byte %h never accepted, required acceptance", b);
                $display("test done: total=%0d bad=%0d", total, bad);
                $fatal(1, "byte stream stalled");
            end
        end
    endtask

    // mode 0: plain load, 1: same-cycle read/write probe on word 1,
    // 2: wr_start pulsed after first byte, 3: reset during word 1.
    task automatic do_load(input bit gaps, input int mode);
        int guard;
        logic [7:0] b;
        wr_start = 1'b1;
        @(posedge clk); #1;
        wr_start  = 1'b0;
        start_cyc = cyc;
        check("start_ready", 32'(bus.in_ready), 32'd1);
        check("start_busy", 32'(load_busy), 32'd1);
        check("start_done_clr", 32'(load_done), 32'd0);
        check("start_count_clr", 32'(wr_count), 32'd0);
        for (int wi = 0; wi < 4; wi++) begin
            for (int bi = 0; bi < 2; bi++) begin
                b = (bi == 0) ? load_w[wi][15:8] : load_w[wi][7:0];
                if (mode == 3 && wi == 1 && bi == 1) begin
                    bus.in_valid = 1'b0;
                    rst_n = 1'b0;
                    #1;
                    check("rst_ready", 32'(bus.in_ready), 32'd0);
                    check("rst_busy", 32'(load_busy), 32'd0);
                    check("rst_done", 32'(load_done), 32'd0);
                    check("rst_count", 32'(wr_count), 32'd0);
                    check("rst_data", 32'(data_out), 32'd0);
                    @(posedge clk); #1;
                    rst_n = 1'b1;
                    model[0] = load_w[0];
                    return;
                end
                send_byte(b, gaps);
                if (mode == 2 && wi == 0 && bi == 0) begin
                    bus.in_valid = 1'b0;
                    wr_start = 1'b1;
                    @(posedge clk); #1;
                    wr_start = 1'b0;
                    check("ignored_start_busy", 32'(load_busy), 32'd1);
                end
            end
            bus.in_valid = 1'b0;
            check("write_cycle_ready", 32'(bus.in_ready), 32'd0);
            if (mode == 1 && wi == 1) begin
                rd(16'd1, model[1]);
                rd(16'd1, load_w[1]);
            end
        end
        guard = 0;
        while (!load_done && guard < 20) begin
            @(posedge clk); #1;
            guard++;
        end
        done_lat = cyc - start_cyc;
        check("done_seen", 32'(load_done), 32'd1);
        check("done_count", 32'(wr_count), 32'd4);
        check("done_ready", 32'(bus.in_ready), 32'd0);
        check("done_busy", 32'(load_busy), 32'd0);
        for (int i = 0; i < 4; i++) model[i] = load_w[i];
    endtask

    initial begin
        void'($urandom(32'd2024));
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_ready", 32'(bus.in_ready), 32'd0);
        check("reset_busy", 32'(load_busy), 32'd0);
        check("reset_done", 32'(load_done), 32'd0);
        check("reset_count", 32'(wr_count), 32'd0);
        check("reset_data", 32'(data_out), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed load, back-to-back bytes.
        load_w = '{16'h1234, 16'hABCD, 16'h0001, 16'hFFEE};
        do_load(1'b0, 0);
        check("load_latency", 32'(done_lat), 32'd12);
        read_all();

        // Out-of-range reads.
        rd(16'd4, 16'h0000);
        rd(16'd3, 16'hFFEE);
        rd(16'hFFFF, 16'h0000);

        // Same-cycle read/write on word 1.
        load_w = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
        do_load(1'b0, 1);
        read_all();

        // Reload from DONE with a stray wr_start mid-load.
        load_w = '{16'h5A5A, 16'hC3C3, 16'h0F0F, 16'h9696};
        do_load(1'b0, 2);
        check("reload_latency", 32'(done_lat), 32'd13);
        read_all();

        // Randomised in_valid gaps.
        for (int n = 0; n < 50; n++) begin
            for (int i = 0; i < 4; i++) load_w[i] = 16'($urandom);
            do_load(1'b1, 0);
            read_all();
        end

        // Reset during word 1: word 0 new, the rest untouched.
        load_w = '{16'hDEAD, 16'hBEEF, 16'hCAFE, 16'hF00D};
        do_load(1'b0, 3);
        read_all();

        // Full load after the aborted one.
        load_w = '{16'h0102, 16'h0304, 16'h0506, 16'h0708};
        do_load(1'b0, 0);
        check("post_reset_latency", 32'(done_lat), 32'd12);
        read_all();

        @(posedge clk); #1;
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
